// File: rtl/mssd_pkg.sv
// mssd_pkg: shared state encoding, header field widths and start-bit level
// for the mssd serializer. GUARD exists only when MSSD_TX_GUARD_EN is defined.
package mssd_pkg;
  localparam int DEST_W = 2;
  localparam int COUNT_W = 4;
  localparam int BYTE_W = 8;
  localparam logic START_BIT = 1'b0;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DEST,
    COUNT,
`ifdef MSSD_TX_GUARD_EN
    DATA,
    GUARD
`else
    DATA
`endif
  } state_t;
endpackage

// File: rtl/mssd_tx_shifter.sv
// mssd_tx_shifter: one-byte hold register feeding an 8-bit shift register.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (empties the hold register)
//   data_in, take  byte written into the hold register when take is high
//   load           move the hold byte into the shift register (hold may refill the same cycle)
//   full           hold register occupied
//   first_bit      MSB of the hold byte, the bit presented right after a load
//   next_bit       bit to present after the current data bit
module mssd_tx_shifter import mssd_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              take,
  input  logic              load,
  output logic              full,
  output logic              first_bit,
  output logic              next_bit
);
  logic [BYTE_W-1:0] hold, sh;
  // The MSB leaves straight from hold on a load, so sh is kept one bit ahead.
  assign first_bit = hold[BYTE_W-1];
  assign next_bit = sh[BYTE_W-1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      sh <= '0;
      full <= 1'b0;
    end else begin
      sh <= load ? {hold[BYTE_W-2:0], 1'b0} : {sh[BYTE_W-2:0], 1'b0};
      if (take) begin
        hold <= data_in;
        full <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/mssd_serializer.sv
// mssd_serializer: frames a request as start bit, dest, count and N payload
// bytes, MSB first, on a registered serial line that idles high.
// Optional guard gap after every frame when MSSD_TX_GUARD_EN is defined.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/req_ready         frame request handshake (req_dest, req_count sampled)
//   data_valid/data_ready       payload byte handshake (data_in)
//   serOut                      serial line
//   busy                        frame on the line
//   frame_done                  pulse after the last bit of a completed frame
//   underrun                    pulse when a frame is dropped for missing data
module mssd_serializer import mssd_pkg::*; #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DEST_W-1:0]  req_dest,
  input  logic [COUNT_W-1:0] req_count,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [BYTE_W-1:0]  data_in,
  output logic               serOut,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);
`ifdef MSSD_TX_GUARD_EN
  localparam state_t end_st = GUARD;
  localparam logic end_ready = 1'b0;
  logic [15:0] gcnt;
`else
  localparam state_t end_st = IDLE;
  localparam logic end_ready = 1'b1;
`endif
  state_t state;
  logic [DEST_W-1:0] dest_r;
  logic [COUNT_W-1:0] cnt_r, fetched, sent;
  logic [2:0] bc;
  logic full, first_bit, next_bit, last_bit, byte_due, load, take;
  assign busy = state inside {START, DEST, COUNT, DATA};
  assign last_bit = (state == COUNT && bc == 3'd3) || (state == DATA && bc == 3'd7);
  assign byte_due = last_bit && sent != cnt_r;
  assign load = byte_due && full;
  // Never accept a byte in the cycle it is found missing: that frame is dropped.
  assign data_ready = busy && fetched != cnt_r && (load || (!full && !byte_due));
  assign take = data_valid && data_ready;
  mssd_tx_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .take      (take),
    .load      (load),
    .full      (full),
    .first_bit (first_bit),
    .next_bit  (next_bit)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      serOut <= 1'b1;
      req_ready <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      dest_r <= '0;
      cnt_r <= '0;
      fetched <= '0;
      sent <= '0;
      bc <= '0;
`ifdef MSSD_TX_GUARD_EN
      gcnt <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      underrun <= 1'b0;
`ifdef MSSD_TX_GUARD_EN
      gcnt <= '0;
`endif
      if (take) fetched <= fetched + 4'd1;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            dest_r <= req_dest;
            cnt_r <= req_count;
            fetched <= '0;
            sent <= '0;
            bc <= '0;
            serOut <= START_BIT;
            state <= START;
          end else begin
            req_ready <= 1'b1;
          end
        end
        START: begin
          serOut <= dest_r[1];
          bc <= '0;
          state <= DEST;
        end
        DEST: begin
          bc <= '0;
          serOut <= bc[0] ? cnt_r[3] : dest_r[0];
          state <= bc[0] ? COUNT : DEST;
          if (!bc[0]) bc <= 3'd1;
        end
        COUNT, DATA: begin
          if (!last_bit) begin
            bc <= bc + 3'd1;
            serOut <= state == COUNT ? cnt_r[2'd2 - bc[1:0]] : next_bit;
          end else if (load) begin
            bc <= '0;
            sent <= sent + 4'd1;
            serOut <= first_bit;
            state <= DATA;
          end else begin
            serOut <= 1'b1;
            state <= end_st;
            req_ready <= end_ready;
            frame_done <= !byte_due;
            underrun <= byte_due;
          end
        end
`ifdef MSSD_TX_GUARD_EN
        GUARD: begin
          if (gcnt == 16'(GUARD_CYCLES - 1)) begin
            state <= IDLE;
            req_ready <= 1'b1;
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mssd_serializer.sv
// tb_mssd_serializer: randomized self-checking bench; expected line bits come
// from a queue built directly from the frame format rules.
module tb_mssd_serializer;
`ifdef MSSD_TX_GUARD_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_ready, data_valid = 0, data_ready;
  logic [1:0] req_dest = 0;
  logic [3:0] req_count = 0;
  logic [7:0] data_in = 0;
  logic serOut, busy, frame_done, underrun;
  logic [7:0] mem [16];
  int total = 0, bad = 0, w;
  always #5 clk = ~clk;
  mssd_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_count  (req_count),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .serOut     (serOut),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // n payload bytes from mem, only the first k ever offered; gaps of up to
  // gmax idle cycles between offers (first offer early enough for the first
  // load); abort_at>0 pulls reset during that bit. w = cycles waited for req_ready.
  task automatic send_frame(input logic [1:0] d, input logic [3:0] n, input int k,
                            input int gmax, input int abort_at, output int wt);
    logic exp_q[$];
    logic [6:0] h;
    int idx, gap, ran;
    logic acc, seen_ready;
    h = {1'b0, d, n};
    for (int i = 6; i >= 0; i--) exp_q.push_back(h[i]);
    for (int b = 0; b < int'(n); b++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(mem[b][i]);
    ran = (k < int'(n)) ? 7 + 8 * k : exp_q.size();
    req_dest = d;
    req_count = n;
    req_valid = 1;
    wt = 0;
    while (!req_ready && wt < 50) begin
      chk("idle_line", serOut, 1);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      wt++;
    end
    chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    idx = 0;
    acc = 0;
    seen_ready = 0;
    gap = $urandom_range(0, gmax < 5 ? gmax : 5);
    for (int c = 1; c <= ran; c++) begin
      if (acc) begin
        idx++;
        gap = $urandom_range(0, gmax);
      end
      chk("bit", serOut, exp_q[c-1]);
      chk("busy", busy, 1);
      chk("req_ready_busy", req_ready, 0);
      chk("no_done", frame_done, 0);
      chk("no_underrun", underrun, 0);
      if (c == abort_at) begin
        #2 reset = 0;
        #1;
        chk("rst_line", serOut, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        data_valid = 0;
        repeat (3) begin
          @(negedge clk);
          chk("rst_done", frame_done, 0);
          chk("rst_underrun", underrun, 0);
          chk("rst_hold_line", serOut, 1);
        end
        reset = 1;
        return;
      end
      seen_ready |= data_ready;
      if (gap > 0) begin
        data_valid = 0;
        gap--;
      end else begin
        data_valid = idx < k;
      end
      data_in = mem[idx];
      acc = data_valid && data_ready;
      @(negedge clk);
    end
    data_valid = 0;
    chk("end_line", serOut, 1);
    chk("end_busy", busy, 0);
    chk("end_done", frame_done, k >= int'(n));
    chk("end_underrun", underrun, k < int'(n));
    if (n == 0) chk("n0_no_ready", seen_ready, 0);
  endtask
  initial begin
    repeat (2) begin
      @(negedge clk);
      chk("reset_line", serOut, 1);
      chk("reset_busy", busy, 0);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_data_ready", data_ready, 0);
      chk("reset_done", frame_done, 0);
      chk("reset_underrun", underrun, 0);
    end
    reset = 1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    mem[0] = 8'hA5;
    send_frame(2'b10, 4'd1, 1, 0, 0, w);
    send_frame(2'b01, 4'd0, 0, 0, 0, w);
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    send_frame(2'($urandom), 4'd3, 1, 3, 0, w);
    send_frame(2'($urandom), 4'd2, 2, 2, 0, w);
    send_frame(2'($urandom), 4'd2, 2, 2, 0, w);
    chk("b2b_gap", w + 1, GAP);
    send_frame(2'($urandom), 4'd4, 4, 3, 10, w);
    send_frame(2'($urandom), 4'd4, 4, 3, 0, w);
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    send_frame(2'($urandom), 4'd15, 15, 7, 0, w);
    for (int t = 0; t < 6; t++) begin
      logic [3:0] n;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      n = 4'($urandom);
      send_frame(2'($urandom), n, int'(n), $urandom_range(0, 7), 0, w);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
